heat_3d_kernel: RTL and testbench
=================================

// Module: heat_3d_kernel
// PURPOSE
// Fixed-point 3-D heat-diffusion (Jacobi 7-point stencil) accelerator with an ap_ctrl_hs start/done handshake.
// It operates in place on an external word-addressed dual-port RAM "A" that holds two N^3 grids, A and B.
// A host wrapper loads the RAM, pulses ap_start, serves RAM requests and unloads the RAM after ap_done.
// PARAMETERS
// N       10  grid edge length; interior indices are 1..N-2 in each dimension
// TSTEPS  20  time steps; each step is two sweeps, A->B then B->A
// AW      16  RAM address width (requires 2*N^3 <= 2^AW)
// DW      32  RAM data width; grid values are signed two's complement
// PORTS
// ap_clk      in   1   clock, all logic on rising edge
// ap_rst      in   1   asynchronous reset, active-high
// ap_start    in   1   start request; may be a 1-cycle pulse
// ap_done     out  1   1-cycle pulse when computation completes
// ap_idle     out  1   high while not running
// ap_ready    out  1   1-cycle pulse, coincident with ap_done
// A_address0  out  AW  port-0 word address
// A_ce0       out  1   port-0 access enable
// A_we0       out  1   port-0 write enable (valid only with A_ce0)
// A_d0        out  DW  port-0 write data
// A_q0        in   DW  port-0 read data, valid the cycle after the ce0 read cycle
// A_address1  out  AW  port-1 word address
// A_ce1       out  1   port-1 access enable
// A_we1       out  1   port-1 write enable; tied 0, port 1 is read-only
// A_d1        out  DW  port-1 write data; tied 0
// A_q1        in   DW  port-1 read data, valid the cycle after the ce1 read cycle
// BEHAVIOUR
// - Memory map: A[i][j][k] is at i*N*N + j*N + k; B[i][j][k] is at N^3 + i*N*N + j*N + k.
// - Reset (asynchronous): FSM goes to IDLE; ap_idle=1; ap_done=ap_ready=0; all ce/we=0; addresses and d=0.
// - IDLE: ap_start=1 is sampled on a clock edge and latched, so a 1-cycle pulse is enough; ap_idle drops the next cycle.
// - ap_start while running is ignored.
// - Sweep loop order: t=0..TSTEPS-1, then src/dst = A->B followed by B->A; i, j, k each run 1..N-2, k innermost.
// - Per point, result is dst = c + ((xp+xm+yp+ym+zp+zm - 6*c) >>> 3).
//   - c is the centre value; xp/xm are i+-1, yp/ym are j+-1, zp/zm are k+-1 neighbours.
//   - The sum is evaluated at DW+4 bits signed; the shift is arithmetic (floor); the result is truncated to DW.
// - Point schedule is a fixed sequence of states per point:
//   - RD0: p0=c,  p1=xm.
//   - RD1: p0=xp, p1=ym.
//   - RD2: p0=yp, p1=zm.
//   - RD3: p0=zp, p1=idle.
//   - CAP: capture q of RD3.
//   - WR:  port 0 writes the result (ce0=we0=1).
//   - Each q is captured exactly one cycle after its ce cycle; at most one access per port per cycle.
//   - Reads of the next point must not start before the previous WR cycle, to avoid read-after-write hazards.
// - Boundary cells (any index 0 or N-1) are never written, in either grid.
// - Completion: after the last WR of the last sweep, pulse ap_done=ap_ready=1 for one cycle, then return to IDLE (ap_idle=1).
// - Final results are in the A region; the B region holds the step-(TSTEPS-1) intermediate grid.
// - ce/we are 0 in every cycle not listed above, including IDLE.
// - Reset asserted mid-run aborts immediately; RAM contents are whatever was already written.
// TESTING
// - All-zero RAM, start pulse -> ap_done after a bounded cycle count; every A and B word still 0; ap_idle=1 afterwards.
// - Every word in both A and B regions = 100 -> all words remain 100; A_we0 is seen only on interior addresses.
// - TSTEPS=1, A centre (5,5,5)=8000, all else 0:
//   - B(5,5,5)=2000; its six neighbours =1000; all other B words 0.
//   - Final A(5,5,5)=1250.
// - A centre=-1, all else 0, TSTEPS=1 -> B centre = -1 + (6 >>> 3) = -1; B neighbours = (-1 >>> 3) = -1 (floor rounding check).
// - Pulse ap_start again mid-run -> ignored, single ap_done; assert ap_rst mid-run -> ce0=ce1=0 at once, ap_idle=1, ap_done never pulses.
// - Protocol monitor on all runs: A_we1 never 1; a read's q is used only one cycle later; ap_done and ap_ready are 1-cycle pulses, coincident.

Source files
------------

// File: rtl/heat_3d_kernel_if.sv
// heat_3d_kernel_if: control handshake plus the two RAM ports of heat_3d_kernel.
//   ap_start/ap_done/ap_idle/ap_ready : start/done handshake
//   A_*0 : RAM port 0 (read/write), A_*1 : RAM port 1 (read-only)
// master = kernel side, slave = host/RAM side.
interface heat_3d_kernel_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 32
);
  logic          ap_start;
  logic          ap_done;
  logic          ap_idle;
  logic          ap_ready;
  logic [AW-1:0] A_address0;
  logic          A_ce0;
  logic          A_we0;
  logic [DW-1:0] A_d0;
  logic [DW-1:0] A_q0;
  logic [AW-1:0] A_address1;
  logic          A_ce1;
  logic          A_we1;
  logic [DW-1:0] A_d1;
  logic [DW-1:0] A_q1;

  modport master (
    input  ap_start, A_q0, A_q1,
    output ap_done, ap_idle, ap_ready,
    output A_address0, A_ce0, A_we0, A_d0,
    output A_address1, A_ce1, A_we1, A_d1
  );

  modport slave (
    output ap_start, A_q0, A_q1,
    input  ap_done, ap_idle, ap_ready,
    input  A_address0, A_ce0, A_we0, A_d0,
    input  A_address1, A_ce1, A_we1, A_d1
  );
endinterface

// File: rtl/heat_3d_kernel.sv
// heat_3d_kernel: in-place Jacobi 7-point 3-D heat stencil over two N^3 grids (A at 0, B at N^3)
// held in an external dual-port RAM. Each time step sweeps A->B then B->A over interior points.
// Ports: ap_clk, ap_rst (async, active-high), bus (heat_3d_kernel_if.master: handshake + RAM).
module heat_3d_kernel #(
  parameter int unsigned N      = 10,
  parameter int unsigned TSTEPS = 20,
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 32
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  heat_3d_kernel_if.master bus
);

  localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;
  localparam int unsigned TW = $clog2(TSTEPS + 1);
  localparam int unsigned SW = DW + 4;

  localparam logic [CW-1:0] FirstIdx = CW'(1);
  localparam logic [CW-1:0] LastIdx  = CW'(N - 2);
  localparam logic [TW-1:0] LastT    = TW'(TSTEPS - 1);
  localparam logic [AW-1:0] StrideI  = AW'(N * N);
  localparam logic [AW-1:0] StrideJ  = AW'(N);
  localparam logic [AW-1:0] GridSize = AW'(N * N * N);

  typedef enum logic [2:0] {StIdle, StRd0, StRd1, StRd2, StRd3, StCap, StWr, StDone} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          i_q, i_d, j_q, j_d, k_q, k_d;
  logic [TW-1:0]          t_q, t_d;
  logic                   dir_q, dir_d;   // 0: A->B, 1: B->A
  logic [DW-1:0]          c_q, c_d;
  logic signed [SW-1:0]   acc_q, acc_d;   // running sum of the six neighbours

  function automatic logic signed [SW-1:0] sext(input logic [DW-1:0] x);
    sext = {{(SW - DW){x[DW-1]}}, x};
  endfunction

  logic [AW-1:0]        ctr, src, dst;
  logic signed [SW-1:0] c_ext, diff, res_full;
  logic                 last_point;

  always_comb begin
    ctr      = AW'(i_q) * StrideI + AW'(j_q) * StrideJ + AW'(k_q);
    src      = (dir_q ? GridSize : '0) + ctr;
    dst      = (dir_q ? '0 : GridSize) + ctr;
    c_ext    = sext(c_q);
    diff     = acc_q - ((c_ext <<< 2) + (c_ext <<< 1));
    res_full = c_ext + (diff >>> 3);
    last_point = (i_q == LastIdx) && (j_q == LastIdx) && (k_q == LastIdx) && dir_q &&
                 (t_q == LastT);
  end

  // State register
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= StIdle;
      i_q     <= FirstIdx;
      j_q     <= FirstIdx;
      k_q     <= FirstIdx;
      t_q     <= '0;
      dir_q   <= 1'b0;
      c_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      t_q     <= t_d;
      dir_q   <= dir_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.ap_start) state_d = StRd0;
      StRd0:   state_d = StRd1;
      StRd1:   state_d = StRd2;
      StRd2:   state_d = StRd3;
      StRd3:   state_d = StCap;
      StCap:   state_d = StWr;
      StWr:    state_d = last_point ? StDone : StRd0;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath / loop counters; each capture consumes the q of the previous cycle's reads
  always_comb begin
    i_d   = i_q;
    j_d   = j_q;
    k_d   = k_q;
    t_d   = t_q;
    dir_d = dir_q;
    c_d   = c_q;
    acc_d = acc_q;
    unique case (state_q)
      StIdle: begin
        i_d   = FirstIdx;
        j_d   = FirstIdx;
        k_d   = FirstIdx;
        t_d   = '0;
        dir_d = 1'b0;
      end
      StRd1: begin
        c_d   = bus.A_q0;
        acc_d = sext(bus.A_q1);
      end
      StRd2, StRd3: acc_d = acc_q + sext(bus.A_q0) + sext(bus.A_q1);
      StCap:        acc_d = acc_q + sext(bus.A_q0);
      StWr: begin
        if (k_q != LastIdx) begin
          k_d = k_q + CW'(1);
        end else begin
          k_d = FirstIdx;
          if (j_q != LastIdx) begin
            j_d = j_q + CW'(1);
          end else begin
            j_d = FirstIdx;
            if (i_q != LastIdx) begin
              i_d = i_q + CW'(1);
            end else begin
              i_d   = FirstIdx;
              dir_d = ~dir_q;
              if (dir_q) t_d = t_q + TW'(1);
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    bus.ap_idle    = (state_q == StIdle);
    bus.ap_done    = (state_q == StDone);
    bus.ap_ready   = (state_q == StDone);
    bus.A_address0 = '0;
    bus.A_ce0      = 1'b0;
    bus.A_we0      = 1'b0;
    bus.A_d0       = '0;
    bus.A_address1 = '0;
    bus.A_ce1      = 1'b0;
    bus.A_we1      = 1'b0;
    bus.A_d1       = '0;
    unique case (state_q)
      StRd0: begin
        bus.A_ce0 = 1'b1; bus.A_address0 = src;
        bus.A_ce1 = 1'b1; bus.A_address1 = src - StrideI;
      end
      StRd1: begin
        bus.A_ce0 = 1'b1; bus.A_address0 = src + StrideI;
        bus.A_ce1 = 1'b1; bus.A_address1 = src - StrideJ;
      end
      StRd2: begin
        bus.A_ce0 = 1'b1; bus.A_address0 = src + StrideJ;
        bus.A_ce1 = 1'b1; bus.A_address1 = src - AW'(1);
      end
      StRd3: begin
        bus.A_ce0 = 1'b1; bus.A_address0 = src + AW'(1);
      end
      StWr: begin
        bus.A_ce0 = 1'b1; bus.A_we0 = 1'b1;
        bus.A_address0 = dst;
        bus.A_d0       = res_full[DW-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_heat_3d_kernel.sv
module tb_heat_3d_kernel;
  localparam int N      = 10;
  localparam int TSTEPS = 1;
  localparam int AW     = 16;
  localparam int DW     = 32;
  localparam int G      = N * N * N;
  localparam int TOT    = 2 * G;
  localparam int BUDGET = 10000;

  logic ap_clk = 1'b0;
  logic ap_rst;

  heat_3d_kernel_if #(.AW(AW), .DW(DW)) bus ();

  heat_3d_kernel #(.N(N), .TSTEPS(TSTEPS), .AW(AW), .DW(DW)) dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .bus   (bus)
  );

  always #5 ap_clk = ~ap_clk;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  logic prev_done = 1'b0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t exp_wr[$];
  int  exp_done_q[$];

  logic [DW-1:0] mem [0:TOT-1];
  logic [DW-1:0] m   [0:TOT-1];

  // Synchronous RAM; q is garbage in any cycle after which no read was issued
  always @(posedge ap_clk) begin
    if (bus.A_ce0) begin
      if (bus.A_we0) mem[bus.A_address0] = bus.A_d0;
      else bus.A_q0 <= mem[bus.A_address0];
    end else begin
      bus.A_q0 <= $urandom;
    end
    if (bus.A_ce1) bus.A_q1 <= mem[bus.A_address1];
    else bus.A_q1 <= $urandom;
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int idx(input int g, input int i, input int j, input int k);
    return g * G + i * N * N + j * N + k;
  endfunction

  function automatic logic signed [DW+3:0] ext(input logic [DW-1:0] x);
    return {{4{x[DW-1]}}, x};
  endfunction

  // Reference model: plain Jacobi sweeps on a copy, pushing every expected write in order
  task automatic build_expected();
    logic signed [DW+3:0] s, cx, v;
    wr_t w;
    for (int a = 0; a < TOT; a++) m[a] = mem[a];
    for (int t = 0; t < TSTEPS; t++)
      for (int dir = 0; dir < 2; dir++)
        for (int i = 1; i <= N - 2; i++)
          for (int j = 1; j <= N - 2; j++)
            for (int k = 1; k <= N - 2; k++) begin
              cx = ext(m[idx(dir, i, j, k)]);
              s  = ext(m[idx(dir, i + 1, j, k)]) + ext(m[idx(dir, i - 1, j, k)]) +
                   ext(m[idx(dir, i, j + 1, k)]) + ext(m[idx(dir, i, j - 1, k)]) +
                   ext(m[idx(dir, i, j, k + 1)]) + ext(m[idx(dir, i, j, k - 1)]);
              v  = cx + ((s - 36'sd6 * cx) >>> 3);
              m[idx(1 - dir, i, j, k)] = v[DW-1:0];
              w.a = AW'(idx(1 - dir, i, j, k));
              w.d = v[DW-1:0];
              exp_wr.push_back(w);
            end
  endtask

  // Monitor: protocol checks every cycle, pops scoreboard on writes and ap_done
  always @(negedge ap_clk) begin
    if (!ap_rst) begin
      int off, ii, jj, kk;
      wr_t w;
      total++;
      if (bus.A_we1 || (bus.ap_done !== bus.ap_ready) || (bus.ap_done && prev_done) ||
          (bus.ap_idle && (bus.A_ce0 || bus.A_ce1)) || (bus.A_we0 && !bus.A_ce0)) begin
        bad++;
        $display("FAIL protocol: we1=%0b done=%0b ready=%0b prev_done=%0b idle=%0b ce0=%0b ce1=%0b we0=%0b",
                 bus.A_we1, bus.ap_done, bus.ap_ready, prev_done, bus.ap_idle, bus.A_ce0,
                 bus.A_ce1, bus.A_we0);
      end
      if (bus.A_ce0 && bus.A_we0) begin
        off = int'(bus.A_address0);
        if (off >= G) off -= G;
        ii = off / (N * N); jj = (off / N) % N; kk = off % N;
        check("write_interior", int'(ii >= 1 && ii <= N - 2 && jj >= 1 && jj <= N - 2 &&
                                     kk >= 1 && kk <= N - 2), 1);
        if (exp_wr.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: addr=%0d data=%0d, none required",
                   bus.A_address0, $signed(bus.A_d0));
        end else begin
          w = exp_wr.pop_front();
          check("write_addr", int'(bus.A_address0), int'(w.a));
          check("write_data", int'(bus.A_d0), int'(w.d));
        end
      end
      if (bus.ap_done) begin
        done_cnt++;
        total++;
        if (exp_done_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done: got ap_done=1 required none");
        end else begin
          void'(exp_done_q.pop_front());
        end
      end
    end
    prev_done <= bus.ap_done;
  end

  task automatic fill(input int val);
    for (int a = 0; a < TOT; a++) mem[a] = DW'(val);
  endtask

  task automatic start_run(input bit want_done);
    build_expected();
    if (want_done) exp_done_q.push_back(1);
    @(negedge ap_clk) bus.ap_start = 1'b1;
    @(negedge ap_clk) bus.ap_start = 1'b0;
    check("idle_drops", int'(bus.ap_idle), 0);
  endtask

  task automatic wait_done();
    int d0, n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < BUDGET) begin
      @(negedge ap_clk);
      n++;
    end
    check("done_within_budget", int'(done_cnt != d0), 1);
    @(negedge ap_clk);
    check("idle_after_done", int'(bus.ap_idle), 1);
    check("writes_all_seen", exp_wr.size(), 0);
    check("done_queue_empty", exp_done_q.size(), 0);
  endtask

  task automatic count_not(input int val, output int cnt);
    cnt = 0;
    for (int a = 0; a < TOT; a++) if (mem[a] !== DW'(val)) cnt++;
  endtask

  initial begin
    int cnt, d0;
    ap_rst = 1'b1;
    bus.ap_start = 1'b0;
    repeat (3) @(negedge ap_clk);
    check("rst_idle", int'(bus.ap_idle), 1);
    check("rst_done", int'(bus.ap_done), 0);
    check("rst_ready", int'(bus.ap_ready), 0);
    check("rst_ce", int'({bus.A_ce0, bus.A_ce1, bus.A_we0}), 0);
    check("rst_addr0", int'(bus.A_address0), 0);
    check("rst_d0", int'(bus.A_d0), 0);
    ap_rst = 1'b0;
    repeat (2) @(negedge ap_clk);

    // All zero
    fill(0);
    start_run(1'b1);
    wait_done();
    count_not(0, cnt);
    check("zero_grid_unchanged", cnt, 0);

    // Uniform 100 stays 100
    fill(100);
    start_run(1'b1);
    wait_done();
    count_not(100, cnt);
    check("uniform_100_unchanged", cnt, 0);

    // Point source 8000 at A(5,5,5)
    fill(0);
    mem[idx(0, 5, 5, 5)] = 32'd8000;
    start_run(1'b1);
    wait_done();
    check("B_centre", int'(mem[idx(1, 5, 5, 5)]), 2000);
    check("B_xp", int'(mem[idx(1, 6, 5, 5)]), 1000);
    check("B_xm", int'(mem[idx(1, 4, 5, 5)]), 1000);
    check("B_yp", int'(mem[idx(1, 5, 6, 5)]), 1000);
    check("B_ym", int'(mem[idx(1, 5, 4, 5)]), 1000);
    check("B_zp", int'(mem[idx(1, 5, 5, 6)]), 1000);
    check("B_zm", int'(mem[idx(1, 5, 5, 4)]), 1000);
    cnt = 0;
    for (int a = G; a < TOT; a++) if (mem[a] != 0) cnt++;
    check("B_nonzero_count", cnt, 7);
    check("A_centre_final", int'(mem[idx(0, 5, 5, 5)]), 1250);

    // Floor rounding with -1 centre
    fill(0);
    mem[idx(0, 5, 5, 5)] = '1;
    start_run(1'b1);
    wait_done();
    check("neg_B_centre", int'(mem[idx(1, 5, 5, 5)]), -1);
    check("neg_B_xp", int'(mem[idx(1, 6, 5, 5)]), -1);
    check("neg_B_zm", int'(mem[idx(1, 5, 5, 4)]), -1);
    check("neg_B_far", int'(mem[idx(1, 2, 2, 2)]), 0);

    // ap_start while running is ignored
    fill(0);
    mem[idx(0, 5, 5, 5)] = 32'd8000;
    d0 = done_cnt;
    start_run(1'b1);
    repeat (300) @(negedge ap_clk);
    bus.ap_start = 1'b1;
    @(negedge ap_clk) bus.ap_start = 1'b0;
    wait_done();
    repeat (50) @(negedge ap_clk);
    check("single_done", done_cnt - d0, 1);
    check("restart_A_centre", int'(mem[idx(0, 5, 5, 5)]), 1250);

    // Reset mid-run aborts
    fill(100);
    d0 = done_cnt;
    start_run(1'b0);
    repeat (500) @(negedge ap_clk);
    ap_rst = 1'b1;
    #1;
    check("abort_ce0", int'(bus.A_ce0), 0);
    check("abort_ce1", int'(bus.A_ce1), 0);
    check("abort_idle", int'(bus.ap_idle), 1);
    exp_wr.delete();
    repeat (5) @(negedge ap_clk);
    ap_rst = 1'b0;
    repeat (100) @(negedge ap_clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_idle_after", int'(bus.ap_idle), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
